// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl
//   Time-multiplexed scan controller for NDIG seven-segment digits sharing a
//   single BCD-to-7-segment decoder. Holds the displayed value, steps a digit
//   index once per DIV-cycle slot, and drives one-hot digit enables with
//   dead-time, leading-zero blanking and invalid-code blanking. New values are
//   staged in a shadow register and only become visible at a frame boundary.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   load       in   single-cycle strobe: din -> shadow, pending <= 1
//   din        in   4*NDIG BCD value, nibble i is digit i (NDIG-1 = MSD)
//   lz_en      in   leading-zero blanking enable (combinational effect)
//   bcd_code   out  nibble of the current digit, to the shared decoder
//   dig_en     out  one-hot active-high digit enable
//   pending    out  shadow holds a value not yet shown
//   frame_tick out  one-cycle pulse in the first cycle of each frame
module bcd_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*NDIG-1:0]   din,
    input  logic                lz_en,
    output logic [3:0]          bcd_code,
    output logic [NDIG-1:0]     dig_en,
    output logic                pending,
    output logic                frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [NDIG-1:0][3:0]   active;
    logic [NDIG-1:0][3:0]   shadow;
    logic                   ft_q;

    logic                   slot_end;
    logic                   boundary;
    logic [3:0]             cur;
    logic                   upper_nz;
    logic                   blank;

    assign slot_end = (cnt == CW'(DIV - 1));
    assign boundary = slot_end && (idx == IW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            // Arms the pulse for the first slot after reset; the output is
            // gated by rst so frame_tick reads 0 while reset is held.
            ft_q    <= 1'b1;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
            end
            if (boundary && pending) begin
                active <= shadow;
            end
            // A load coinciding with the boundary keeps pending set: the
            // old shadow moves to active while din becomes the new shadow.
            if (load) begin
                shadow  <= din;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            ft_q <= boundary;
        end
    end

    assign frame_tick = ft_q & ~rst;

    always_comb begin
        cur      = active[idx];
        bcd_code = cur;

        // Any non-zero nibble at or above the current digit keeps it lit.
        upper_nz = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (i >= 32'(idx) && active[i] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end

        blank = (cur > 4'd9) || (lz_en && (idx != '0) && !upper_nz);

        dig_en = '0;
        if ((cnt >= CW'(BLANK_CYC)) && !blank) begin
            dig_en[idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb_bcd_scan_ctrl
//   Self-checking bench for bcd_scan_ctrl (NDIG=4, DIV=8, BLANK_CYC=2).
//   A reference model tracks time since reset and derives slot, phase and
//   expected outputs arithmetically from the displayed value.
module tb_bcd_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  bcd_code;
    logic [3:0]  dig_en;
    logic        pending;
    logic        frame_tick;

    int          n_cmp = 0;
    int          n_err = 0;

    // reference model state
    int          t = 0;
    logic [15:0] m_act = '0;
    logic [15:0] m_sh = '0;
    logic        m_pend = 1'b0;
    bit          mvalid = 1'b0;

    logic        r_i, ld_i, lz_i;
    logic [15:0] d_i;

    bcd_scan_ctrl #(
        .NDIG(NDIG),
        .DIV(DIV),
        .BLANK_CYC(BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .din(din),
        .lz_en(lz_en),
        .bcd_code(bcd_code),
        .dig_en(dig_en),
        .pending(pending),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model across the rising edge.
    task automatic tick(input logic r, input logic ld, input logic [15:0] d, input logic lz);
        int          slot;
        int          ph;
        int          nib;
        logic [15:0] upper;
        logic [15:0] e_en;
        rst = r; load = ld; din = d; lz_en = lz;
        #1;
        if (mvalid) begin
            slot  = (t / DIV) % NDIG;
            ph    = t % DIV;
            upper = m_act >> (4 * slot);
            nib   = int'(upper & 16'hF);
            e_en  = '0;
            if (ph >= BLANK && nib <= 9 && !(lz && slot > 0 && upper == 16'd0))
                e_en = 16'(1) << slot;
            chk("bcd_code",   {12'd0, bcd_code},   16'(nib));
            chk("dig_en",     {12'd0, dig_en},     e_en);
            chk("pending",    {15'd0, pending},    {15'd0, m_pend});
            chk("frame_tick", {15'd0, frame_tick}, (!r && (t % FRAME) == 0) ? 16'd1 : 16'd0);
        end
        @(posedge clk);
        if (r) begin
            t = 0; m_act = '0; m_sh = '0; m_pend = 1'b0; mvalid = 1'b1;
        end else if (mvalid) begin
            if ((t % FRAME) == FRAME - 1 && m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_sh   = d;
                m_pend = 1'b1;
            end
            t++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic lz);
        repeat (n) tick(1'b0, 1'b0, 16'd0, lz);
    endtask

    task automatic sync_to(input int target, input logic lz);
        int k = 0;
        while ((t % FRAME) != target && k < 2 * FRAME) begin
            tick(1'b0, 1'b0, 16'd0, lz);
            k++;
        end
        if ((t % FRAME) != target) begin
            n_err++;
            $display("FAIL sync: frame position %0d required %0d", t % FRAME, target);
        end
    endtask

    initial begin
        @(negedge clk);
        // reset and idle scan
        repeat (3) tick(1'b1, 1'b0, 16'd0, 1'b0);
        idle(70, 1'b0);
        // mid-frame load becomes visible at next frame
        sync_to(13, 1'b0);
        tick(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(70, 1'b0);
        // leading-zero blanking
        sync_to(10, 1'b0);
        tick(1'b0, 1'b1, 16'h0042, 1'b0);
        sync_to(0, 1'b0);
        idle(32, 1'b1);
        idle(32, 1'b0);
        tick(1'b0, 1'b1, 16'h0000, 1'b1);
        sync_to(0, 1'b1);
        idle(32, 1'b1);
        // invalid-code blanking
        tick(1'b0, 1'b1, 16'h9A35, 1'b0);
        sync_to(0, 1'b0);
        idle(32, 1'b0);
        idle(32, 1'b1);
        // load in the boundary cycle
        sync_to(5, 1'b0);
        tick(1'b0, 1'b1, 16'h1111, 1'b0);
        sync_to(31, 1'b0);
        tick(1'b0, 1'b1, 16'h2222, 1'b0);
        idle(64, 1'b0);
        // reset mid-slot with a pending value
        tick(1'b0, 1'b1, 16'h5678, 1'b0);
        sync_to(21, 1'b0);
        tick(1'b1, 1'b0, 16'd0, 1'b0);
        idle(40, 1'b0);
        // randomized traffic
        lz_i = 1'b0;
        repeat (600) begin
            r_i  = ($urandom_range(0, 199) == 0);
            ld_i = ($urandom_range(0, 9) == 0);
            d_i  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d_i = d_i >> (4 * $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) lz_i = ~lz_i;
            tick(r_i, ld_i, d_i, lz_i);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
